// File: rtl/booth_pp_if.sv
// Handshake bundle between a radix-4 Booth encoder and the partial-product accumulator.
// The master drives operands and out_ready; the slave returns the product and its status.
interface booth_pp_if #(
    parameter int PP_W = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic signed [PP_W-1:0] pp_a;
    logic signed [PP_W-1:0] pp_b;
    logic signed [PP_W-1:0] pp_c;
    logic signed [PP_W-1:0] pp_d;
    logic                   out_valid;
    logic                   out_ready;
    logic signed [PP_W-1:0] product;
    logic                   busy;

    modport master (
        output in_valid, pp_a, pp_b, pp_c, pp_d, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, pp_a, pp_b, pp_c, pp_d, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/booth_pp_accumulator.sv
// Sums four pre-weighted Booth partial products serially, one per cycle, into a
// PP_W-bit wrap-around product presented with a valid/ready handshake.
module booth_pp_accumulator #(
    parameter int PP_W   = 16,
    parameter int NUM_PP = 4
) (
    input logic       clk,
    input logic       rst_n,
    booth_pp_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_e;

    localparam logic [1:0] LAST_IDX = 2'(NUM_PP - 1);

    state_e                 state_q, state_d;
    logic [1:0]             idx_q, idx_d;
    logic [PP_W-1:0]        acc_q, acc_d;
    logic [PP_W-1:0]        product_q, product_d;
    logic                   out_valid_q, out_valid_d;
    logic [3:0][PP_W-1:0]   pp_reg_q, pp_reg_d;
    logic [PP_W-1:0]        sum;

    // Carry-out is dropped on purpose: the product is defined modulo 2^PP_W.
    assign sum = acc_q + pp_reg_q[idx_q];

    always_comb begin
        // NOTE: every next-state signal defaults to its current value so no path leaves it unassigned (no latches).
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        product_d   = product_q;
        out_valid_d = out_valid_q;
        pp_reg_d    = pp_reg_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    pp_reg_d = {bus.pp_d, bus.pp_c, bus.pp_b, bus.pp_a};
                    acc_d    = '0;
                    idx_d    = '0;
                    state_d  = ACC;
                end
            end
            ACC: begin
                acc_d = sum;
                idx_d = idx_q + 2'd1;
                if (idx_q == LAST_IDX) begin
                    idx_d       = '0;
                    product_d   = sum;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // NOTE: the captured operand registers are reset too, so an aborted operation leaves no stale data behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
            pp_reg_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            product_q   <= product_d;
            out_valid_q <= out_valid_d;
            pp_reg_q    <= pp_reg_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.product   = product_q;

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Directed bench for booth_pp_accumulator: hand-computed sums, latency, backpressure,
// input stability, mid-operation reset and back-to-back operation.
module tb_booth_pp_accumulator;

    logic clk;
    logic rst_n;
    int   vectors     = 0;
    int   miscompares = 0;

    booth_pp_if #(.PP_W(16)) bus ();

    booth_pp_accumulator #(
        .PP_W  (16),
        .NUM_PP(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_set(input logic [15:0] a, b, c, d);
        bus.pp_a = a;
        bus.pp_b = b;
        bus.pp_c = c;
        bus.pp_d = d;
    endtask

    // Call right after a falling edge; the set is accepted on the next rising edge.
    task automatic do_op(input string tag, input logic [15:0] a, b, c, d,
                         input logic [15:0] exp, input int stall, input bit scramble);
        drive_set(a, b, c, d);
        bus.in_valid  = 1'b1;
        bus.out_ready = (stall == 0);
        @(negedge clk);
        bus.in_valid = scramble;
        check({tag, ".busy_e0"}, 16'(bus.busy), 16'd1);
        check({tag, ".in_ready_e0"}, 16'(bus.in_ready), 16'd0);
        for (int k = 1; k <= 3; k++) begin
            if (scramble) drive_set(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            @(negedge clk);
            check({tag, ".out_valid_early"}, 16'(bus.out_valid), 16'd0);
        end
        if (scramble) drive_set(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        @(negedge clk);
        check({tag, ".out_valid"}, 16'(bus.out_valid), 16'd1);
        check({tag, ".product"}, bus.product, exp);
        check({tag, ".in_ready_done"}, 16'(bus.in_ready), 16'd0);
        bus.in_valid = (stall != 0);
        for (int k = 0; k < stall; k++) begin
            drive_set(16'h5555, 16'h5555, 16'h5555, 16'h5555);
            @(negedge clk);
            check({tag, ".stall_valid"}, 16'(bus.out_valid), 16'd1);
            check({tag, ".stall_product"}, bus.product, exp);
            check({tag, ".stall_in_ready"}, 16'(bus.in_ready), 16'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check({tag, ".out_valid_drop"}, 16'(bus.out_valid), 16'd0);
        check({tag, ".in_ready_idle"}, 16'(bus.in_ready), 16'd1);
        @(negedge clk);
        check({tag, ".busy_idle"}, 16'(bus.busy), 16'd0);
        check({tag, ".product_hold"}, bus.product, exp);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive_set(16'h0, 16'h0, 16'h0, 16'h0);

        // Reset state is visible before any clock edge.
        #2;
        check("rst.in_ready", 16'(bus.in_ready), 16'd1);
        check("rst.busy", 16'(bus.busy), 16'd0);
        check("rst.out_valid", 16'(bus.out_valid), 16'd0);
        check("rst.product", bus.product, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 10*10 via Booth: -20 - 40 + 160 + 0 = 100, accepted on the first edge after release.
        do_op("basic", 16'hFFEC, 16'hFFD8, 16'h00A0, 16'h0000, 16'h0064, 0, 1'b0);
        do_op("wrap_pos", 16'h7FFF, 16'h0001, 16'h0000, 16'h0000, 16'h8000, 0, 1'b0);
        do_op("wrap_neg", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFC, 0, 1'b0);
        do_op("backpressure", 16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h1014, 3, 1'b0);
        do_op("stability", 16'h1234, 16'h0101, 16'h0010, 16'h0001, 16'h1346, 0, 1'b1);

        // Back-to-back: in_valid held high, second set accepted one edge after the handshake.
        drive_set(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        drive_set(16'h0100, 16'hFF00, 16'h0020, 16'h0003);
        check("b2b.busy_e0", 16'(bus.busy), 16'd1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("b2b.in_ready_acc", 16'(bus.in_ready), 16'd0);
        end
        @(negedge clk);
        check("b2b.out_valid1", 16'(bus.out_valid), 16'd1);
        check("b2b.product1", bus.product, 16'h000A);
        @(negedge clk);
        check("b2b.out_valid1_drop", 16'(bus.out_valid), 16'd0);
        check("b2b.in_ready_gap", 16'(bus.in_ready), 16'd1);
        @(negedge clk);
        check("b2b.accept2", 16'(bus.busy), 16'd1);
        bus.in_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("b2b.out_valid2_early", 16'(bus.out_valid), 16'd0);
        end
        @(negedge clk);
        check("b2b.out_valid2", 16'(bus.out_valid), 16'd1);
        check("b2b.product2", bus.product, 16'h0023);
        @(negedge clk);
        check("b2b.out_valid2_drop", 16'(bus.out_valid), 16'd0);

        // Reset mid-ACC aborts the operation and clears the held product.
        drive_set(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst.busy", 16'(bus.busy), 16'd0);
        check("midrst.out_valid", 16'(bus.out_valid), 16'd0);
        check("midrst.product", bus.product, 16'h0000);
        check("midrst.in_ready", 16'(bus.in_ready), 16'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_op("after_rst", 16'h0005, 16'h0006, 16'h0007, 16'h0008, 16'h001A, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
